sevenseg_scan_driver: RTL and testbench

- Downstream consumer of the stopwatch counter's BCD digits (m1 m2 : s1 s2). Drives a 4-digit common-anode multiplexed 7-segment display: one digit at a time, with active-low anodes, segments and decimal point.
- Provides tear-free shadow capture, leading-zero blanking, a blinking colon (DP of minutes-units digit) and a global blank.

---
 rtl/sevenseg_scan_driver.sv | 130 +++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed 4-digit common-anode 7-segment driver for an mm:ss stopwatch.
// Shadow-captures BCD digits once per scan; handles leading-zero blanking, colon blink and global blank.
module sevenseg_scan_driver #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_SCANS = 250,
  parameter bit LZB_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] m1,
  input  logic [3:0] m2,
  input  logic [2:0] s1,
  input  logic [3:0] s2,
  input  logic       blank,
  input  logic       colon_blink,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_SCANS - 1);
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [BLK_W-1:0] scan_cnt;
  logic             colon_ph;
  logic             primed;
  logic [2:0]       sh_m1, sh_s1;
  logic [3:0]       sh_m2, sh_s2;

  logic             tick, wrap, capture;
  logic [3:0]       sel_digit;
  logic             sel_tens;
  logic             lead_zero;
  logic             colon_on;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic tens);
    if (tens && v > 4'd5) return SEG_DASH;
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  assign tick    = (div_cnt == DIV_LAST);
  assign wrap    = tick && (idx == 2'd3);
  // Until the first post-reset cycle the shadows hold zeros, so capture immediately once.
  assign capture = wrap || !primed;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      idx      <= 2'd0;
      scan_cnt <= '0;
      colon_ph <= 1'b1;
      primed   <= 1'b0;
      sh_m1    <= 3'd0;
      sh_m2    <= 4'd0;
      sh_s1    <= 3'd0;
      sh_s2    <= 4'd0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) idx <= idx + 2'd1;
      primed <= 1'b1;
      if (capture) begin
        sh_m1 <= m1;
        sh_m2 <= m2;
        sh_s1 <= s1;
        sh_s2 <= s2;
      end
      if (wrap) begin
        if (scan_cnt == BLK_LAST) begin
          scan_cnt <= '0;
          colon_ph <= ~colon_ph;
        end else begin
          scan_cnt <= scan_cnt + BLK_W'(1);
        end
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    sel_digit = sh_s2;
    sel_tens  = 1'b0;
    case (idx)
      2'd0: begin sel_digit = sh_s2;         sel_tens = 1'b0; end
      2'd1: begin sel_digit = {1'b0, sh_s1}; sel_tens = 1'b1; end
      2'd2: begin sel_digit = sh_m2;         sel_tens = 1'b0; end
      2'd3: begin sel_digit = {1'b0, sh_m1}; sel_tens = 1'b1; end
      default: ;
    endcase
    lead_zero = LZB_EN && (idx == 2'd3) && (sh_m1 == 3'd0);
    colon_on  = colon_blink ? colon_ph : 1'b1;
    an_d      = (blank || lead_zero) ? 4'b1111 : ~(4'b0001 << idx);
    seg_d     = seg_decode(sel_digit, sel_tens);
    dp_d      = !((idx == 2'd2) && colon_on && !blank);
  end

  // Anode, segments and DP register on the same edge so no digit ever shows its neighbour's pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_n  <= 4'b1111;
      seg_n <= 7'b1111111;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_d;
      seg_n <= seg_d;
      dp_n  <= dp_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver: directed scenarios plus randomized traffic
// compared every cycle against a cycle-count based reference model.
module tb_sevenseg_scan_driver;

  localparam int D    = 4;
  localparam int B    = 2;
  localparam int SCAN = 4 * D;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] m1 = 3'd0, s1 = 3'd0;
  logic [3:0] m2 = 4'd0, s2 = 4'd0;
  logic       blank = 1'b0, colon_blink = 1'b0;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  int errors = 0;
  int checks = 0;

  sevenseg_scan_driver #(.SCAN_DIV(D), .BLINK_SCANS(B), .LZB_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .m1(m1), .m2(m2), .s1(s1), .s2(s2),
    .blank(blank), .colon_blink(colon_blink),
    .an_n(an_a), .seg_n(seg_a), .dp_n(dp_a)
  );

  sevenseg_scan_driver #(.SCAN_DIV(D), .BLINK_SCANS(B), .LZB_EN(1'b0)) dut_nolzb (
    .clk(clk), .reset(reset), .m1(m1), .m2(m2), .s1(s1), .s2(s2),
    .blank(blank), .colon_blink(colon_blink),
    .an_n(an_b), .seg_n(seg_b), .dp_n(dp_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v, input bit tens);
    if (v > 4'd9 || (tens && v > 4'd5)) return 7'b0111111;
    return SEG_TAB[v];
  endfunction

  // Position inside the scan follows directly from the number of edges since reset.
  function automatic int idx_of(input int k);
    return (k % SCAN) / D;
  endfunction

  // Colon phase starts lit and flips after every B completed scans.
  function automatic bit ph_of(input int k);
    return ((k / SCAN) / B) % 2 == 0;
  endfunction

  function automatic logic [3:0] an_of(input int i);
    logic [3:0] a;
    a = 4'b1111;
    a[i] = 1'b0;
    return a;
  endfunction

  // Reference model: n counts non-reset edges; shadows refresh on the first edge and at each scan end.
  int         n = 0;
  int         m_idx = -1;
  bit         model_valid = 1'b0;
  logic [3:0] sh [4] = '{default: 4'h0};
  logic [3:0] e_an_a = 4'hF, e_an_b = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;

  always @(posedge clk) begin
    model_valid <= 1'b1;
    if (reset) begin
      n      <= 0;
      m_idx  <= -1;
      sh     <= '{default: 4'h0};
      e_an_a <= 4'hF;
      e_an_b <= 4'hF;
      e_seg  <= 7'h7F;
      e_dp   <= 1'b1;
    end else begin
      m_idx  <= idx_of(n);
      e_seg  <= dec(sh[idx_of(n)], idx_of(n) % 2 == 1);
      e_an_b <= blank ? 4'hF : an_of(idx_of(n));
      e_an_a <= (blank || (idx_of(n) == 3 && sh[3] == 4'h0)) ? 4'hF : an_of(idx_of(n));
      e_dp   <= !(idx_of(n) == 2 && (!colon_blink || ph_of(n)) && !blank);
      if (n == 0 || n % SCAN == SCAN - 1) begin
        sh[0] <= s2;
        sh[1] <= {1'b0, s1};
        sh[2] <= m2;
        sh[3] <= {1'b0, m1};
      end
      n <= n + 1;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("an_lzb",    8'(an_a),  8'(e_an_a));
      check("an_nolzb",  8'(an_b),  8'(e_an_b));
      check("seg_lzb",   8'(seg_a), 8'(e_seg));
      check("seg_nolzb", 8'(seg_b), 8'(e_seg));
      check("dp_lzb",    8'(dp_a),  8'(e_dp));
      check("dp_nolzb",  8'(dp_b),  8'(e_dp));
    end
  end

  // Advance to the first cycle of a fresh slot showing digit i.
  task automatic goto_idx(input int i);
    int k;
    for (k = 0; k < 4 * SCAN && m_idx == i; k++) @(negedge clk);
    for (k = 0; k < 4 * SCAN && m_idx != i; k++) @(negedge clk);
    check("goto_idx", 8'(m_idx), 8'(i));
  endtask

  localparam logic [3:0] AN_SEQ  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] SEG_SEQ [4] = '{7'b0010000, 7'b0010010, 7'b0010000, 7'b0010010};

  initial begin
    m1 = 3'd5; m2 = 4'd9; s1 = 3'd5; s2 = 4'd9;
    blank = 1'b0; colon_blink = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_an",  8'(an_a),  8'hF);
    check("rst_seg", 8'(seg_a), 8'h7F);
    check("rst_dp",  8'(dp_a),  8'h1);
    reset = 1'b0;

    // 59:59 over one steady scan
    repeat (SCAN) @(negedge clk);
    for (int j = 0; j < SCAN; j++) begin
      @(negedge clk);
      check("scan_an",  8'(an_a),  8'(AN_SEQ[j / D]));
      check("scan_seg", 8'(seg_a), 8'(SEG_SEQ[j / D]));
      check("scan_dp",  8'(dp_a),  8'((j / D == 2) ? 1'b0 : 1'b1));
    end

    // Leading-zero blanking on m1 = 0
    m1 = 3'd0; m2 = 4'd3;
    repeat (2 * SCAN) @(negedge clk);
    goto_idx(3);
    check("lzb_an",    8'(an_a),  8'hF);
    check("nolzb_an",  8'(an_b),  8'(4'b0111));
    check("nolzb_seg", 8'(seg_b), 8'(7'b1000000));
    goto_idx(2);
    check("m2_seg",    8'(seg_a), 8'(7'b0110000));

    // Mid-scan change only shows after the wrap
    s2 = 4'd7;
    repeat (2 * SCAN) @(negedge clk);
    goto_idx(0);
    check("s2_old", 8'(seg_a), 8'(7'b1111000));
    goto_idx(1);
    s2 = 4'd6;
    goto_idx(0);
    check("s2_new", 8'(seg_a), 8'(7'b0000010));

    // Input change in the wrap cycle itself is the value captured
    for (int k = 0; k < 2 * SCAN && (n % SCAN) != SCAN - 1; k++) @(negedge clk);
    check("wrap_pos", 8'(n % SCAN), 8'(SCAN - 1));
    s2 = 4'd2;
    @(negedge clk);
    s2 = 4'd9;
    goto_idx(0);
    check("wrap_capture", 8'(seg_a), 8'(7'b0100100));

    // Colon blink from a clean reset: lit for scans 0,1, dark for 2,3, ...
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    colon_blink = 1'b1;
    for (int s = 0; s < 8; s++) begin
      goto_idx(2);
      check("colon_blink", 8'(dp_a), 8'(((s / 2) % 2 == 0) ? 1'b0 : 1'b1));
    end
    colon_blink = 1'b0;
    for (int s = 0; s < 2; s++) begin
      goto_idx(2);
      check("colon_steady", 8'(dp_a), 8'h0);
    end

    // Illegal units-of-seconds value shows a dash
    s2 = 4'hC;
    repeat (2 * SCAN) @(negedge clk);
    goto_idx(0);
    check("illegal_seg", 8'(seg_a), 8'(7'b0111111));

    // Global blank for 5 clocks
    blank = 1'b1;
    @(negedge clk);
    check("blank_an", 8'(an_a), 8'hF);
    repeat (4) @(negedge clk);
    blank = 1'b0;
    repeat (SCAN) @(negedge clk);

    // Reset in the middle of the minutes-units slot
    goto_idx(2);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_an",  8'(an_a),  8'hF);
    check("midrst_seg", 8'(seg_a), 8'h7F);
    check("midrst_dp",  8'(dp_a),  8'h1);
    reset = 1'b0;
    @(negedge clk);
    check("restart_an",  8'(an_a),  8'(4'b1110));
    check("restart_seg", 8'(seg_a), 8'(7'b1000000));

    // Randomized traffic; the per-cycle model comparison does the checking
    repeat (2000) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        m1 = 3'($urandom_range(0, 7));
        m2 = 4'($urandom_range(0, 15));
        s1 = 3'($urandom_range(0, 7));
        s2 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 19) == 0) blank = ~blank;
      if ($urandom_range(0, 99) == 0) colon_blink = ~colon_blink;
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
